// File: rtl/wormhole_lock_arbiter.sv
// Wormhole collision arbiter: the first wormhole hit locks out all others for
// HOLD_SECS one-second ticks and emits a registered per-object teleport pulse.
module wormhole_lock_arbiter #(
    parameter int NUM_OBJ   = 3,
    parameter int NUM_WH    = 2,
    parameter int HOLD_SECS = 2,
    localparam int WH_W     = ($clog2(NUM_WH) > 1) ? $clog2(NUM_WH) : 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      oneSec,
    input  logic                      abort,
    input  logic [NUM_OBJ*NUM_WH-1:0] collision_in,
    output logic [NUM_OBJ*NUM_WH-1:0] collision_out,
    output logic                      lock_valid,
    output logic [WH_W-1:0]           lock_wh,
    output logic [3:0]                secs_left,
    output logic [NUM_OBJ-1:0]        teleport_pulse
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_HOLD = 1'b1;

    logic                state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [WH_W-1:0]     lock_wh_n;
    logic [3:0]          secs_left_n;
    logic [NUM_OBJ-1:0]  tp_n;
    logic [NUM_WH-1:0]   any_wh;
    logic                win_found;
    logic [WH_W-1:0]     win_idx;
    logic [WH_W-1:0]     sel_wh;
    logic                pass_en;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        any_wh = '0;
        for (int o = 0; o < NUM_OBJ; o++)
            for (int w = 0; w < NUM_WH; w++)
                any_wh[w] = any_wh[w] | collision_in[o*NUM_WH + w];
    end

    // Fixed priority: the lowest-index wormhole with any hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int w = 0; w < NUM_WH; w++) begin
            if (any_wh[w] && !win_found) begin
                win_found = 1'b1;
                win_idx   = WH_W'(w);
            end
        end
    end

    assign sel_wh  = (state == S_HOLD) ? lock_wh : win_idx;
    assign pass_en = !abort && ((state == S_HOLD) || win_found);

    always_comb begin
        collision_out = '0;
        for (int o = 0; o < NUM_OBJ; o++)
            for (int w = 0; w < NUM_WH; w++)
                collision_out[o*NUM_WH + w] = pass_en && (WH_W'(w) == sel_wh)
                                              && collision_in[o*NUM_WH + w];
    end

    // In S_IDLE the filtered bits are exactly the objects on the winning wormhole.
    always_comb begin
        tp_n = '0;
        for (int o = 0; o < NUM_OBJ; o++)
            tp_n[o] = (state == S_IDLE) && (|collision_out[o*NUM_WH +: NUM_WH]);
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lock_wh_n = lock_wh;
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else if (state == S_IDLE) begin
            if (win_found) begin
                state_n   = S_HOLD;
                cnt_n     = '0;
                lock_wh_n = win_idx;
            end
        end else if (oneSec) begin
            if (cnt == 4'(HOLD_SECS - 1)) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 4'd1;
            end
        end
        secs_left_n = (state_n == S_HOLD) ? (4'(HOLD_SECS) - cnt_n) : 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lock_wh        <= '0;
            secs_left      <= '0;
            teleport_pulse <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            lock_wh        <= lock_wh_n;
            secs_left      <= secs_left_n;
            teleport_pulse <= tp_n;
        end
    end

    assign lock_valid = (state == S_HOLD);

endmodule

// File: tb/tb_wormhole_lock_arbiter.sv
// Scoreboard bench: each scenario queues per-cycle stimulus with its expected
// filtered output and next-cycle registered outputs, then replays and compares.
module tb_wormhole_lock_arbiter;

    typedef struct {
        bit         inst;   // 0: HOLD_SECS=2 instance, 1: HOLD_SECS=3 instance
        logic [5:0] cin;
        logic       tick;
        logic       ab;
        logic [5:0] cout;
        logic [8:0] regs;   // {lock_valid, lock_wh, secs_left, teleport_pulse}
    } step_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick_a = 1'b0, abort_a = 1'b0, tick_b = 1'b0, abort_b = 1'b0;
    logic [5:0] cin_a = '0, cin_b = '0, cout_a, cout_b;
    logic       lv_a, lv_b, lw_a, lw_b;
    logic [3:0] sl_a, sl_b;
    logic [2:0] tp_a, tp_b;

    int checks = 0;
    int errors = 0;
    step_t sb[$];

    always #5 clk = ~clk;

    wormhole_lock_arbiter #(.NUM_OBJ(3), .NUM_WH(2), .HOLD_SECS(2)) u_dut (
        .clk(clk), .resetN(resetN), .oneSec(tick_a), .abort(abort_a),
        .collision_in(cin_a), .collision_out(cout_a), .lock_valid(lv_a),
        .lock_wh(lw_a), .secs_left(sl_a), .teleport_pulse(tp_a)
    );

    wormhole_lock_arbiter #(.NUM_OBJ(3), .NUM_WH(2), .HOLD_SECS(3)) u_dut3 (
        .clk(clk), .resetN(resetN), .oneSec(tick_b), .abort(abort_b),
        .collision_in(cin_b), .collision_out(cout_b), .lock_valid(lv_b),
        .lock_wh(lw_b), .secs_left(sl_b), .teleport_pulse(tp_b)
    );

    function automatic step_t mk(bit inst, logic [5:0] cin, logic tick, logic ab,
                                 logic [5:0] cout, logic lv, logic lw,
                                 logic [3:0] sl, logic [2:0] tp);
        step_t s;
        s.inst = inst; s.cin = cin; s.tick = tick; s.ab = ab;
        s.cout = cout; s.regs = {lv, lw, sl, tp};
        return s;
    endfunction

    function automatic logic [5:0] obs_cout(bit inst);
        return inst ? cout_b : cout_a;
    endfunction

    function automatic logic [8:0] obs_regs(bit inst);
        return inst ? {lv_b, lw_b, sl_b, tp_b} : {lv_a, lw_a, sl_a, tp_a};
    endfunction

    task automatic drive(step_t s);
        @(negedge clk);
        cin_a   = s.inst ? 6'd0 : s.cin;
        tick_a  = s.inst ? 1'b0 : s.tick;
        abort_a = s.inst ? 1'b0 : s.ab;
        cin_b   = s.inst ? s.cin : 6'd0;
        tick_b  = s.inst ? s.tick : 1'b0;
        abort_b = s.inst ? s.ab : 1'b0;
    endtask

    task automatic test_reset;
        step_t e;
        int n = 0;
        #1;
        checks++;
        if ({lv_a, lw_a, sl_a, tp_a, cout_a} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values got %b required 0", {lv_a, lw_a, sl_a, tp_a, cout_a});
        end
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) sb.push_back(mk(0, 6'b000000, 0, 0, 6'b000000, 0, 0, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL reset_idle step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL reset_idle step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_lock_mask;
        step_t e;
        int n = 0;
        sb.push_back(mk(0, 6'b001000, 0, 0, 6'b001000, 1, 1, 4'd2, 3'b010));
        sb.push_back(mk(0, 6'b000001, 0, 0, 6'b000000, 1, 1, 4'd2, 3'b000));
        sb.push_back(mk(0, 6'b001001, 0, 0, 6'b001000, 1, 1, 4'd2, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 1, 1, 4'd1, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 0, 1, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b000000, 0, 0, 6'b000000, 0, 1, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL lock_mask step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL lock_mask step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_priority;
        step_t e;
        int n = 0;
        sb.push_back(mk(0, 6'b010010, 0, 0, 6'b010000, 1, 0, 4'd2, 3'b100));
        sb.push_back(mk(0, 6'b000010, 0, 0, 6'b000000, 1, 0, 4'd2, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 1, 0, 4'd1, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 0, 0, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL priority step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL priority step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_hold3;
        step_t e;
        int n = 0;
        sb.push_back(mk(1, 6'b001000, 1, 0, 6'b001000, 1, 1, 4'd3, 3'b010));
        sb.push_back(mk(1, 6'b000000, 1, 0, 6'b000000, 1, 1, 4'd2, 3'b000));
        sb.push_back(mk(1, 6'b000000, 1, 0, 6'b000000, 1, 1, 4'd1, 3'b000));
        sb.push_back(mk(1, 6'b000000, 0, 0, 6'b000000, 1, 1, 4'd1, 3'b000));
        sb.push_back(mk(1, 6'b000000, 1, 0, 6'b000000, 0, 1, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL hold3 step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL hold3 step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_abort;
        step_t e;
        int n = 0;
        sb.push_back(mk(0, 6'b000100, 0, 0, 6'b000100, 1, 0, 4'd2, 3'b010));
        sb.push_back(mk(0, 6'b000100, 0, 1, 6'b000000, 0, 0, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b100000, 0, 0, 6'b100000, 1, 1, 4'd2, 3'b100));
        sb.push_back(mk(0, 6'b100000, 1, 1, 6'b000000, 0, 1, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b000001, 0, 1, 6'b000000, 0, 1, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b000000, 0, 0, 6'b000000, 0, 1, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL abort step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL abort step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back;
        step_t e;
        int n = 0;
        sb.push_back(mk(0, 6'b000101, 0, 0, 6'b000101, 1, 0, 4'd2, 3'b011));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 1, 0, 4'd1, 3'b000));
        sb.push_back(mk(0, 6'b000010, 1, 0, 6'b000000, 0, 0, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b000010, 0, 0, 6'b000010, 1, 1, 4'd2, 3'b001));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 1, 1, 4'd1, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 0, 1, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL back_to_back step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL back_to_back step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_hold;
        step_t e;
        int n = 0;
        sb.push_back(mk(0, 6'b001000, 0, 0, 6'b001000, 1, 1, 4'd2, 3'b010));
        sb.push_back(mk(0, 6'b000000, 0, 0, 6'b000000, 1, 1, 4'd2, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL reset_mid_hold step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL reset_mid_hold step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checks++;
        if ({lv_a, lw_a, sl_a, tp_a} !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_hold async regs got %b required 0", {lv_a, lw_a, sl_a, tp_a});
        end
        @(negedge clk);
        resetN = 1'b1;
        sb.push_back(mk(0, 6'b000000, 0, 0, 6'b000000, 0, 0, 4'd0, 3'b000));
        sb.push_back(mk(0, 6'b000001, 0, 0, 6'b000001, 1, 0, 4'd2, 3'b001));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 1, 0, 4'd1, 3'b000));
        sb.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 0, 0, 4'd0, 3'b000));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e);
            #1;
            checks++;
            if (obs_cout(e.inst) !== e.cout) begin
                errors++;
                $display("FAIL after_reset step%0d collision_out got %b required %b", n, obs_cout(e.inst), e.cout);
            end
            @(posedge clk); #1;
            checks++;
            if (obs_regs(e.inst) !== e.regs) begin
                errors++;
                $display("FAIL after_reset step%0d regs got %b required %b", n, obs_regs(e.inst), e.regs);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_lock_mask();
        test_priority();
        test_hold3();
        test_abort();
        test_back_to_back();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
